// File: rtl/urv_mem_arbiter_pkg.sv
// Shared definitions for the uRV memory arbiter: FSM state encodings.
package urv_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_FETCH = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/urv_mem_arbiter.sv
// Shares the single memory bus between instruction fetch and the data port.
// Data wins by default; a starvation counter forces a fetch after STARVE_LIMIT data grants.
module urv_mem_arbiter
   import urv_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] im_addr_i,
   input  logic        im_rd_i,
   output logic [31:0] im_data_o,
   output logic        im_valid_o,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_load_i,
   input  logic        dm_store_i,
   output logic        dm_ready_o,
   output logic [31:0] dm_data_l_o,
   output logic        dm_load_done_o,
   output logic        dm_store_done_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_sel_o,
   output logic        bus_we_o,
   output logic        bus_req_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] starve_cnt;
   logic          starved, data_acc, fetch_acc, ack_seen, fetch_flushed;

   assign starved    = im_rd_i && (starve_cnt == CW'(STARVE_LIMIT));
   assign dm_ready_o = (state == ARB_IDLE) && !starved;
   assign data_acc   = dm_ready_o && (dm_load_i || dm_store_i);
   assign fetch_acc  = (state == ARB_IDLE) && im_rd_i && !data_acc;
   // Acks outside a transaction are stray and must not complete anything
   assign ack_seen   = (state != ARB_IDLE) && bus_ack_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (data_acc)       state_nxt = ARB_DATA;
            else if (fetch_acc) state_nxt = ARB_FETCH;
         end
         ARB_DATA, ARB_FETCH: if (bus_ack_i) state_nxt = ARB_IDLE;
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) starve_cnt <= '0;
      else if (!im_rd_i || fetch_acc) starve_cnt <= '0;
      else if (data_acc && !starved) starve_cnt <= starve_cnt + CW'(1);
   end

   // Bus request and transfer attributes; frozen while a transfer is outstanding
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bus_req_o   <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_sel_o   <= '0;
         bus_we_o    <= 1'b0;
      end else if (data_acc) begin
         bus_req_o   <= 1'b1;
         bus_addr_o  <= dm_addr_i;
         bus_wdata_o <= dm_data_s_i;
         bus_sel_o   <= dm_data_select_i;
         bus_we_o    <= dm_store_i;   // load+store together is treated as a store
      end else if (fetch_acc) begin
         bus_req_o   <= 1'b1;
         bus_addr_o  <= im_addr_i;
         bus_wdata_o <= '0;
         bus_sel_o   <= 4'hF;
         bus_we_o    <= 1'b0;
      end else if (ack_seen) begin
         bus_req_o   <= 1'b0;
      end
   end

   // A fetch whose request drops before the ack is a flush: finish the bus cycle silently
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                fetch_flushed <= 1'b0;
      else if (fetch_acc)                        fetch_flushed <= 1'b0;
      else if (state == ARB_FETCH && !im_rd_i)   fetch_flushed <= 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         im_valid_o      <= 1'b0;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         im_data_o       <= '0;
         dm_data_l_o     <= '0;
      end else begin
         im_valid_o      <= ack_seen && (state == ARB_FETCH) && im_rd_i && !fetch_flushed;
         dm_load_done_o  <= ack_seen && (state == ARB_DATA) && !bus_we_o;
         dm_store_done_o <= ack_seen && (state == ARB_DATA) && bus_we_o;
         if (ack_seen && (state == ARB_FETCH) && im_rd_i && !fetch_flushed)
            im_data_o <= bus_rdata_i;
         if (ack_seen && (state == ARB_DATA) && !bus_we_o)
            dm_data_l_o <= bus_rdata_i;
      end
   end

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter: vector table of single transactions plus
// hand-written collision, starvation, flush and reset sequences.
module tb_urv_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] im_addr_i = '0;
   logic        im_rd_i = 1'b0;
   logic [31:0] im_data_o;
   logic        im_valid_o;
   logic [31:0] dm_addr_i = '0;
   logic [31:0] dm_data_s_i = '0;
   logic [3:0]  dm_data_select_i = '0;
   logic        dm_load_i = 1'b0;
   logic        dm_store_i = 1'b0;
   logic        dm_ready_o;
   logic [31:0] dm_data_l_o;
   logic        dm_load_done_o;
   logic        dm_store_done_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_sel_o;
   logic        bus_we_o;
   logic        bus_req_o;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_ack_i = 1'b0;

   int passed = 0;
   int total  = 0;

   urv_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .im_addr_i(im_addr_i), .im_rd_i(im_rd_i), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
      .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
      .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(dm_ready_o),
      .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
      .bus_we_o(bus_we_o), .bus_req_o(bus_req_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // The execute stage never issues load and store together
   always @(posedge clk_i)
      if (rst_i) assert (!(dm_load_i && dm_store_i)) else $error("load and store asserted together");

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // kind: 0 fetch, 1 load, 2 store
   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] rdata;
      int          wt;
      logic        e_we;
      logic [3:0]  e_sel;
      logic [31:0] e_wdata;
      logic        e_imv;
      logic        e_ld;
      logic        e_st;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input vec_t v, input int idx);
      string p;
      p = $sformatf("vec%0d", idx);
      if (v.kind == 0) begin
         im_rd_i = 1'b1; im_addr_i = v.addr;
         dm_data_s_i = 32'hFFFF_FFFF;   // stray store data must not leak into a fetch
      end else begin
         chk({p, " ready"}, {31'd0, dm_ready_o}, 32'd1);
         dm_addr_i = v.addr; dm_data_s_i = v.wdata; dm_data_select_i = v.sel;
         if (v.kind == 1) dm_load_i = 1'b1; else dm_store_i = 1'b1;
      end
      @(negedge clk_i);
      dm_load_i = 1'b0; dm_store_i = 1'b0;
      chk({p, " req"},   {31'd0, bus_req_o}, 32'd1);
      chk({p, " addr"},  bus_addr_o, v.addr);
      chk({p, " we"},    {31'd0, bus_we_o}, {31'd0, v.e_we});
      chk({p, " sel"},   {28'd0, bus_sel_o}, {28'd0, v.e_sel});
      chk({p, " wdata"}, bus_wdata_o, v.e_wdata);
      for (int w = 0; w < v.wt; w++) begin
         @(negedge clk_i);
         chk({p, " hold"}, {bus_req_o, bus_addr_o[30:0]}, {1'b1, v.addr[30:0]});
      end
      bus_ack_i = 1'b1; bus_rdata_i = v.rdata;
      @(negedge clk_i);
      bus_ack_i = 1'b0; bus_rdata_i = '0;
      chk({p, " done"}, {29'd0, im_valid_o, dm_load_done_o, dm_store_done_o},
          {29'd0, v.e_imv, v.e_ld, v.e_st});
      chk({p, " req_drop"}, {31'd0, bus_req_o}, 32'd0);
      if (v.kind == 0) chk({p, " im_data"}, im_data_o, v.e_rd);
      if (v.kind == 1) chk({p, " ld_data"}, dm_data_l_o, v.e_rd);
      im_rd_i = 1'b0;
      @(negedge clk_i);
      chk({p, " pulse_end"}, {29'd0, im_valid_o, dm_load_done_o, dm_store_done_o}, 32'd0);
   endtask

   initial begin
      //          kind addr          wdata          sel    rdata          wt we sel   e_wdata        imv ld st e_rd
      vecs[0] = '{0, 32'h0000_0100, 32'h0,         4'h0, 32'h0000_0013, 2, 0, 4'hF, 32'h0,         1, 0, 0, 32'h0000_0013};
      vecs[1] = '{2, 32'h0000_2004, 32'hDEAD_BEEF, 4'hC, 32'h0,         0, 1, 4'hC, 32'hDEAD_BEEF, 0, 0, 1, 32'h0};
      vecs[2] = '{1, 32'h0000_3008, 32'h0,         4'h3, 32'h1234_5678, 1, 0, 4'h3, 32'h0,         0, 1, 0, 32'h1234_5678};
      vecs[3] = '{0, 32'h0000_0104, 32'h0,         4'h0, 32'h0010_0093, 0, 0, 4'hF, 32'h0,         1, 0, 0, 32'h0010_0093};
      vecs[4] = '{2, 32'h0000_4000, 32'hA5A5_0F0F, 4'hF, 32'h0,         3, 1, 4'hF, 32'hA5A5_0F0F, 0, 0, 1, 32'h0};

      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst req",   {31'd0, bus_req_o}, 32'd0);
      chk("rst pulses", {29'd0, im_valid_o, dm_load_done_o, dm_store_done_o}, 32'd0);
      chk("rst bus",   {bus_addr_o ^ bus_wdata_o, bus_sel_o, bus_we_o}, 37'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst ready", {31'd0, dm_ready_o}, 32'd1);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Collision: data wins, fetch follows at the next IDLE cycle
      im_rd_i = 1'b1; im_addr_i = 32'h200;
      dm_load_i = 1'b1; dm_addr_i = 32'h3000; dm_data_select_i = 4'hF;
      @(negedge clk_i);
      dm_load_i = 1'b0;
      chk("col first addr", bus_addr_o, 32'h3000);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_5555;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      chk("col ld done", {30'd0, dm_load_done_o, im_valid_o}, 32'd2);
      chk("col ld data", dm_data_l_o, 32'hAAAA_5555);
      chk("col gap req", {31'd0, bus_req_o}, 32'd0);
      @(negedge clk_i);
      chk("col fetch", {bus_req_o, bus_sel_o, bus_addr_o}, {1'b1, 4'hF, 32'h200});
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0033;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      chk("col im done", {30'd0, dm_load_done_o, im_valid_o}, 32'd1);
      chk("col im data", im_data_o, 32'h33);
      im_rd_i = 1'b0;
      @(negedge clk_i);

      // Starvation: four data grants, then the pending fetch is forced through
      im_rd_i = 1'b1; im_addr_i = 32'h400; dm_data_select_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("starve ready%0d", i), {31'd0, dm_ready_o}, 32'd1);
         dm_store_i = 1'b1; dm_addr_i = 32'h5000 + i; dm_data_s_i = 32'h100 + i;
         @(negedge clk_i);
         dm_store_i = 1'b0;
         chk($sformatf("starve grant%0d", i), {bus_we_o, bus_addr_o}, {1'b1, 32'h5000 + i});
         bus_ack_i = 1'b1;
         @(negedge clk_i);
         bus_ack_i = 1'b0;
         chk($sformatf("starve st_done%0d", i), {31'd0, dm_store_done_o}, 32'd1);
      end
      chk("starve blocked", {31'd0, dm_ready_o}, 32'd0);
      dm_store_i = 1'b1; dm_addr_i = 32'h6000;   // lost: not ready
      @(negedge clk_i);
      dm_store_i = 1'b0;
      chk("starve fetch", {bus_we_o, bus_sel_o, bus_addr_o}, {1'b0, 4'hF, 32'h400});
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0073;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      chk("starve im done", {31'd0, im_valid_o}, 32'd1);
      chk("starve cnt clr", {31'd0, dm_ready_o}, 32'd1);
      im_rd_i = 1'b0;
      @(negedge clk_i);

      // Flush: fetch request withdrawn before the ack
      im_rd_i = 1'b1; im_addr_i = 32'h600;
      @(negedge clk_i);
      chk("flush req", {31'd0, bus_req_o}, 32'd1);
      im_rd_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("flush hold", {31'd0, bus_req_o}, 32'd1);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      chk("flush no valid", {31'd0, im_valid_o}, 32'd0);
      chk("flush ready", {31'd0, dm_ready_o}, 32'd1);
      chk("flush im_data kept", im_data_o, 32'h73);

      // Reset mid-transaction, then a late ack while idle
      dm_load_i = 1'b1; dm_addr_i = 32'h700;
      @(negedge clk_i);
      dm_load_i = 1'b0;
      chk("mid req", {31'd0, bus_req_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      chk("mid rst req", {31'd0, bus_req_o}, 32'd0);
      chk("mid rst pulses", {29'd0, im_valid_o, dm_load_done_o, dm_store_done_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      @(negedge clk_i);
      chk("late ack ignored", {28'd0, im_valid_o, dm_load_done_o, dm_store_done_o, bus_req_o}, 32'd0);
      chk("late ack ld data", dm_data_l_o, 32'd0);
      chk("late ack ready", {31'd0, dm_ready_o}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
